// File: rtl/spi_xfer_ctrl_if.sv
// Host-side command/response bundle for spi_xfer_ctrl.
// master = host issuing commands, slave = transaction controller.
interface spi_xfer_ctrl_if #(
    parameter int P_DATA_WIDTH = 32
) ();
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_rd;
    logic [7:0]              cmd_nbits;
    logic [P_DATA_WIDTH-1:0] cmd_wdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [P_DATA_WIDTH-1:0] rsp_rdata;
    logic                    rsp_err;

    modport master (
        output cmd_valid, cmd_rd, cmd_nbits, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_rd, cmd_nbits, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI transaction controller: CS setup/hold, timing words, master req/ack.
// Optional REQ watchdog enabled by defining SPI_XFER_TIMEOUT_EN.
module spi_xfer_ctrl #(
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_xfer_ctrl_if.slave          host,
    input  logic [15:0]             cfg_half,
    input  logic                    cfg_cpol,
    input  logic [15:0]             cfg_miso_dly,
    input  logic [7:0]              cfg_cs_setup,
    input  logic [7:0]              cfg_cs_hold,
    output logic                    cs_n,
    output logic                    spi_wr_req,
    output logic                    spi_rd_req,
    output logic [P_DATA_WIDTH-1:0] spi_wr_data,
    input  logic [P_DATA_WIDTH-1:0] spi_rd_data,
    input  logic                    spi_ack,
    output logic [7:0]              spi_nb,
    output logic                    spi_y0_mosi,
    output logic                    spi_y0_sclk,
    output logic [31:0]             spi_n0_mosi,
    output logic [31:0]             spi_n1_mosi,
    output logic [31:0]             spi_n0_miso,
    output logic [31:0]             spi_n1_miso,
    output logic [31:0]             spi_n0_sclk,
    output logic [31:0]             spi_n1_sclk,
    output logic [31:0]             spi_n2_sclk
);
    localparam int W = P_DATA_WIDTH;
    localparam logic [7:0] MAX_NB = 8'(P_DATA_WIDTH);
    localparam logic [W-1:0] ONES = '1;

    typedef enum logic [2:0] {
        IDLE, SETUP, REQ, REL, HOLD, RSP
    } state_t;

    state_t         state_q, state_d;
    logic           cmd_ready_q, cmd_ready_d;
    logic           cs_n_q, cs_n_d;
    logic           wr_req_q, wr_req_d;
    logic           rd_req_q, rd_req_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_err_q, rsp_err_d;
    logic [W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           rd_q, rd_d;
    logic [7:0]     nbits_q, nbits_d;
    logic [15:0]    half_q, half_d;
    logic           cpol_q, cpol_d;
    logic [15:0]    miso_dly_q, miso_dly_d;
    logic [7:0]     setup_q, setup_d;
    logic [7:0]     hold_q, hold_d;
    logic [W-1:0]   wr_data_q, wr_data_d;
    logic [W-1:0]   rd_mask;
    logic           bad_len;
`ifdef SPI_XFER_TIMEOUT_EN
    logic [31:0]    wd_q, wd_d;
    logic [31:0]    wd_limit;
`endif

    assign bad_len = (host.cmd_nbits == 8'd0) || (host.cmd_nbits > MAX_NB);
    assign rd_mask = ~(ONES << nbits_q);
`ifdef SPI_XFER_TIMEOUT_EN
    assign wd_limit = (32'(nbits_q) + 32'd2) * 32'd2 * 32'(half_q)
                    + 32'(miso_dly_q) + 32'd64;
`endif

    // Next-state and registered-output computation for the transfer FSM
    always_comb begin
        state_d     = state_q;
        cs_n_d      = cs_n_q;
        wr_req_d    = wr_req_q;
        rd_req_d    = rd_req_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        nbits_d     = nbits_q;
        half_d      = half_q;
        cpol_d      = cpol_q;
        miso_dly_d  = miso_dly_q;
        setup_d     = setup_q;
        hold_d      = hold_q;
        wr_data_d   = wr_data_q;
`ifdef SPI_XFER_TIMEOUT_EN
        wd_d        = wd_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (host.cmd_valid) begin
                    rd_d        = host.cmd_rd;
                    nbits_d     = host.cmd_nbits;
                    half_d      = cfg_half;
                    cpol_d      = cfg_cpol;
                    miso_dly_d  = cfg_miso_dly;
                    setup_d     = cfg_cs_setup;
                    hold_d      = cfg_cs_hold;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    cnt_d       = 8'd0;
                    if (bad_len) begin
                        // Bad length never touches the bus
                        wr_data_d   = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RSP;
                    end else begin
                        wr_data_d = host.cmd_wdata << (MAX_NB - host.cmd_nbits);
                        cs_n_d    = 1'b0;
                        state_d   = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == setup_q) begin
                    wr_req_d = 1'b1;
                    rd_req_d = rd_q;
                    state_d  = REQ;
`ifdef SPI_XFER_TIMEOUT_EN
                    wd_d     = 32'd0;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            REQ: begin
                if (spi_ack) begin
                    wr_req_d    = 1'b0;
                    rd_req_d    = 1'b0;
                    rsp_rdata_d = rd_q ? (spi_rd_data & rd_mask) : '0;
                    state_d     = REL;
                end
`ifdef SPI_XFER_TIMEOUT_EN
                else if (wd_q + 32'd1 == wd_limit) begin
                    wr_req_d    = 1'b0;
                    rd_req_d    = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = REL;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
`endif
            end
            REL: begin
                if (!spi_ack) begin
                    cnt_d   = 8'd0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == hold_q) begin
                    cs_n_d  = 1'b1;
                    state_d = RSP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RSP: begin
                if (rsp_valid_q && host.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            cs_n_q      <= 1'b1;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cnt_q       <= 8'd0;
            rd_q        <= 1'b0;
            nbits_q     <= 8'd0;
            half_q      <= 16'd0;
            cpol_q      <= 1'b0;
            miso_dly_q  <= 16'd0;
            setup_q     <= 8'd0;
            hold_q      <= 8'd0;
            wr_data_q   <= '0;
`ifdef SPI_XFER_TIMEOUT_EN
            wd_q        <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cs_n_q      <= cs_n_d;
            wr_req_q    <= wr_req_d;
            rd_req_q    <= rd_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            nbits_q     <= nbits_d;
            half_q      <= half_d;
            cpol_q      <= cpol_d;
            miso_dly_q  <= miso_dly_d;
            setup_q     <= setup_d;
            hold_q      <= hold_d;
            wr_data_q   <= wr_data_d;
`ifdef SPI_XFER_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign host.cmd_ready = cmd_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_err   = rsp_err_q;
    assign host.rsp_rdata = rsp_rdata_q;

    assign cs_n        = cs_n_q;
    assign spi_wr_req  = wr_req_q;
    assign spi_rd_req  = rd_req_q;
    assign spi_wr_data = wr_data_q;
    assign spi_nb      = nbits_q;
    assign spi_y0_mosi = 1'b0;
    assign spi_y0_sclk = cpol_q;
    assign spi_n0_mosi = 32'd0;
    assign spi_n1_mosi = {15'd0, half_q, 1'b0};
    assign spi_n0_miso = {16'd0, miso_dly_q};
    assign spi_n1_miso = {15'd0, half_q, 1'b0};
    assign spi_n0_sclk = {16'd0, half_q};
    assign spi_n1_sclk = {16'd0, half_q};
    assign spi_n2_sclk = {16'd0, half_q};
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl with a behavioural SPI master ack model.
// Define SPI_XFER_TIMEOUT_EN to also exercise the REQ watchdog.
module tb_spi_xfer_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cfg_half;
    logic        cfg_cpol;
    logic [15:0] cfg_miso_dly;
    logic [7:0]  cfg_cs_setup;
    logic [7:0]  cfg_cs_hold;
    logic        cs_n, spi_wr_req, spi_rd_req, spi_ack;
    logic [31:0] spi_wr_data, spi_rd_data;
    logic [7:0]  spi_nb;
    logic        spi_y0_mosi, spi_y0_sclk;
    logic [31:0] spi_n0_mosi, spi_n1_mosi, spi_n0_miso, spi_n1_miso;
    logic [31:0] spi_n0_sclk, spi_n1_sclk, spi_n2_sclk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    // master model controls
    bit   ack_en = 1'b1;
    int   ack_dly = 3;
    int   acnt;

    spi_xfer_ctrl_if #(.P_DATA_WIDTH(32)) host ();

    spi_xfer_ctrl #(.P_DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host         (host),
        .cfg_half     (cfg_half),
        .cfg_cpol     (cfg_cpol),
        .cfg_miso_dly (cfg_miso_dly),
        .cfg_cs_setup (cfg_cs_setup),
        .cfg_cs_hold  (cfg_cs_hold),
        .cs_n         (cs_n),
        .spi_wr_req   (spi_wr_req),
        .spi_rd_req   (spi_rd_req),
        .spi_wr_data  (spi_wr_data),
        .spi_rd_data  (spi_rd_data),
        .spi_ack      (spi_ack),
        .spi_nb       (spi_nb),
        .spi_y0_mosi  (spi_y0_mosi),
        .spi_y0_sclk  (spi_y0_sclk),
        .spi_n0_mosi  (spi_n0_mosi),
        .spi_n1_mosi  (spi_n1_mosi),
        .spi_n0_miso  (spi_n0_miso),
        .spi_n1_miso  (spi_n1_miso),
        .spi_n0_sclk  (spi_n0_sclk),
        .spi_n1_sclk  (spi_n1_sclk),
        .spi_n2_sclk  (spi_n2_sclk)
    );

    always #5 clk = ~clk;

    // SPI master stand-in: ack after ack_dly+1 request cycles, drop when req drops
    always @(posedge clk) begin
        if (!rst_n) begin
            spi_ack <= 1'b0;
            acnt    <= 0;
        end else if (spi_wr_req && !spi_ack && ack_en) begin
            if (acnt == ack_dly) spi_ack <= 1'b1;
            else acnt <= acnt + 1;
        end else if (!spi_wr_req) begin
            spi_ack <= 1'b0;
            acnt    <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction; to_lim != 0 means ack is withheld and the watchdog fires
    task automatic xfer(input bit rd, input int nb, input logic [31:0] wd,
                        input logic [31:0] mrd, input int su, input int ho,
                        input int hf, input bit cp, input int rdy_dly,
                        input int to_lim);
        exp_t        e;
        logic [31:0] mask;
        bit          bad;
        int          k;
        bad  = (nb == 0) || (nb > 32);
        mask = (nb >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
        e.err   = bad || (to_lim != 0);
        e.rdata = (e.err || !rd) ? 32'd0 : (mrd & mask);
        sb.push_back(e);

        chk("cmd_ready_idle", host.cmd_ready, 1);
        cfg_half      = 16'(hf);
        cfg_cpol      = cp;
        cfg_cs_setup  = 8'(su);
        cfg_cs_hold   = 8'(ho);
        spi_rd_data   = mrd;
        host.cmd_rd    = rd;
        host.cmd_nbits = 8'(nb);
        host.cmd_wdata = wd;
        host.cmd_valid = 1'b1;
        tick();
        host.cmd_valid = 1'b0;
        chk("cmd_ready_busy", host.cmd_ready, 0);

        if (bad) begin
            chk("bad_rsp_valid", host.rsp_valid, 1);
            chk("bad_cs_n", cs_n, 1);
            chk("bad_wr_req", spi_wr_req, 0);
            chk("bad_rd_req", spi_rd_req, 0);
        end else begin
            chk("cs_fall", cs_n, 0);
            k = 0;
            while (!spi_wr_req && k < 500) begin
                tick();
                k++;
            end
            chk("req_setup_lat", k, su + 1);
            chk("rd_req", spi_rd_req, rd);
            chk("wr_data", spi_wr_data, 32'(wd << (32 - nb)));
            chk("nb", spi_nb, nb);
            chk("n1_mosi", spi_n1_mosi, 2 * hf);
            chk("n0_mosi", spi_n0_mosi, 0);
            chk("n1_miso", spi_n1_miso, 2 * hf);
            chk("n0_miso", spi_n0_miso, cfg_miso_dly);
            chk("sclk_words", {spi_n0_sclk, spi_n2_sclk},
                {32'(hf), 32'(hf)});
            chk("n1_sclk", spi_n1_sclk, hf);
            chk("y0_levels", {spi_y0_sclk, spi_y0_mosi}, {cp, 1'b0});
            if (to_lim != 0) begin
                k = 0;
                while (spi_wr_req && k < to_lim + 50) begin
                    tick();
                    k++;
                end
                chk("wdog_limit", k, to_lim);
                chk("wdog_rd_req", spi_rd_req, 0);
            end else begin
                k = 0;
                while (!spi_ack && k < 500) begin
                    tick();
                    k++;
                end
                chk("ack_seen", spi_ack, 1);
                tick();
                chk("req_drop", {spi_wr_req, spi_rd_req}, 0);
            end
            k = 0;
            while (spi_ack && k < 500) begin
                tick();
                k++;
            end
            // ack low now; dut samples it on the next edge, then hold+1 more
            k = 0;
            while (!cs_n && k < 600) begin
                tick();
                k++;
            end
            chk("cs_hold_lat", k, ho + 2);
            chk("rsp_lag", host.rsp_valid, 0);
            tick();
            chk("rsp_rise", host.rsp_valid, 1);
        end

        for (int i = 0; i < rdy_dly; i++) begin
            chk("stall_valid", host.rsp_valid, 1);
            chk("stall_cmd_ready", host.cmd_ready, 0);
            chk("stall_rdata", host.rsp_rdata, sb[0].rdata);
            tick();
        end
        host.rsp_ready = 1'b1;
        chk("hs_valid", host.rsp_valid, 1);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("rsp_err", host.rsp_err, e.err);
            chk("rsp_rdata", host.rsp_rdata, e.rdata);
        end
        tick();
        host.rsp_ready = 1'b0;
        chk("post_valid", host.rsp_valid, 0);
        chk("post_cmd_ready", host.cmd_ready, 1);
        chk("post_cs_n", cs_n, 1);
    endtask

    initial begin
        rst_n          = 1'b0;
        host.cmd_valid = 1'b0;
        host.cmd_rd    = 1'b0;
        host.cmd_nbits = 8'd0;
        host.cmd_wdata = 32'd0;
        host.rsp_ready = 1'b0;
        cfg_half       = 16'd1;
        cfg_cpol       = 1'b1;
        cfg_miso_dly   = 16'd3;
        cfg_cs_setup   = 8'd0;
        cfg_cs_hold    = 8'd0;
        spi_rd_data    = 32'd0;
        repeat (3) tick();

        chk("rst_cmd_ready", host.cmd_ready, 1);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_reqs", {spi_wr_req, spi_rd_req}, 0);
        chk("rst_rsp", {host.rsp_valid, host.rsp_err}, 0);
        chk("rst_rdata", host.rsp_rdata, 0);
        chk("rst_y0_sclk", spi_y0_sclk, 0);
        chk("rst_words", {spi_n1_mosi, spi_n0_sclk}, 0);
        rst_n = 1'b1;
        tick();

        xfer(0, 8, 32'hA5, 32'hDEAD_BEEF, 1, 1, 2, 0, 0, 0);
        xfer(1, 12, 32'h123, 32'hFFFF_F3C1, 3, 5, 3, 1, 0, 0);
        xfer(1, 32, 32'h1234_5678, 32'h89AB_CDEF, 0, 0, 1, 0, 10, 0);
        xfer(1, 1, 32'h1, 32'hFFFF_FFFE, 2, 0, 5, 1, 1, 0);
        xfer(0, 0, 32'h55, 32'hFFFF_FFFF, 0, 0, 1, 0, 2, 0);
        xfer(1, 33, 32'h55, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0);

        for (int n = 0; n < 4; n++) begin
            ack_dly = int'($urandom_range(0, 5));
            xfer(1'($urandom_range(0, 1)), int'($urandom_range(1, 32)),
                 $urandom, $urandom, int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)), int'($urandom_range(1, 4)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0);
        end
        ack_dly = 3;

        // reset while in SETUP
        cfg_cs_setup   = 8'd5;
        cfg_half       = 16'd2;
        host.cmd_rd    = 1'b1;
        host.cmd_nbits = 8'd8;
        host.cmd_valid = 1'b1;
        tick();
        host.cmd_valid = 1'b0;
        chk("rst_pre_cs", cs_n, 0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_cs_n", cs_n, 1);
        chk("midrst_cmd_ready", host.cmd_ready, 1);
        chk("midrst_reqs", {spi_wr_req, spi_rd_req}, 0);
        chk("midrst_words", spi_n1_mosi, 0);
        rst_n = 1'b1;
        tick();

`ifdef SPI_XFER_TIMEOUT_EN
        // limit = (8+2)*2*2 + 3 + 64
        ack_en = 1'b0;
        cfg_miso_dly = 16'd3;
        xfer(1, 8, 32'h3C, 32'hFFFF_FFFF, 0, 1, 2, 0, 0, 107);
        ack_en = 1'b1;
`endif

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
